nios_system_nios2_qsys_dct_packer: RTL

NIOS_SYSTEM_NIOS2_QSYS_DCT_PACKER -- requirements
Module: nios_system_nios2_qsys_dct_packer

---
 rtl/nios_system_dct_pkg.sv | 26 ++
 rtl/nios_system_dct_timeout_ctr.sv | 30 +++
 rtl/nios_system_nios2_qsys_dct_packer.sv | 117 +++++++++++
 3 files changed

// File: rtl/nios_system_dct_pkg.sv
// Shared types and constants for the DCT trace-atom packer.
package nios_system_dct_pkg;

    localparam int DCT_ATOM_W = 2;
    localparam int DCT_SLOTS  = 15;
    localparam int DCT_BUF_W  = 30;
    localparam int DCT_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } dct_state_e;

    // Place an atom into slot 'slot'; slot k occupies bits [2k+1:2k].
    function automatic logic [DCT_BUF_W-1:0] dct_slot_insert(
        input logic [DCT_BUF_W-1:0]  buf_in,
        input logic [DCT_CNT_W-1:0]  slot,
        input logic [DCT_ATOM_W-1:0] atom_in
    );
        logic [DCT_BUF_W-1:0] ext;
        ext = {{(DCT_BUF_W-DCT_ATOM_W){1'b0}}, atom_in};
        return buf_in | (ext << {slot, 1'b0});
    endfunction

endpackage

// File: rtl/nios_system_dct_timeout_ctr.sv
// Idle-cycle counter for the packer's partial-frame flush; only built when
// NIOS_SYSTEM_DCT_TIMEOUT_EN is defined.
module nios_system_dct_timeout_ctr #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int W = 10;

    logic [W-1:0] cnt_q;

    // Fires during the LIMIT-th consecutive idle cycle so the FSM moves at that edge.
    assign expired = run && !clear && (cnt_q == W'(LIMIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (run && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/nios_system_nios2_qsys_dct_packer.sv
// Packs 2-bit trace atoms into 15-slot frames with a valid/ready output handshake.
// Optional idle flush of partial frames is enabled by NIOS_SYSTEM_DCT_TIMEOUT_EN.
module nios_system_nios2_qsys_dct_packer
    import nios_system_dct_pkg::*;
#(
    parameter int FLUSH_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  atom_valid,
    input  logic [DCT_ATOM_W-1:0] atom,
    output logic                  atom_ready,
    input  logic                  test_ending,
    output logic [DCT_BUF_W-1:0]  dct_buffer,
    output logic [DCT_CNT_W-1:0]  dct_count,
    output logic                  dct_valid,
    input  logic                  dct_ready,
    output logic                  test_has_ended
);

    dct_state_e           state_q;
    logic [DCT_BUF_W-1:0] buf_q;
    logic [DCT_CNT_W-1:0] cnt_q;
    logic                 end_pend_q;

    logic                 accept;
    logic [DCT_BUF_W-1:0] buf_ins;
    logic [DCT_CNT_W-1:0] cnt_inc;
    logic [DCT_CNT_W-1:0] cnt_after;
    logic                 tmo_expired;

    assign accept    = atom_valid && (state_q == ST_FILL);
    assign buf_ins   = dct_slot_insert(buf_q, cnt_q, atom);
    assign cnt_inc   = cnt_q + 1'b1;
    assign cnt_after = accept ? cnt_inc : cnt_q;

`ifdef NIOS_SYSTEM_DCT_TIMEOUT_EN
    localparam int TMO_LIMIT = (FLUSH_TIMEOUT < 2)    ? 2    :
                               (FLUSH_TIMEOUT > 1023) ? 1023 : FLUSH_TIMEOUT;

    logic tmo_clear;
    logic tmo_run;

    assign tmo_clear = accept || (state_q != ST_FILL);
    assign tmo_run   = (state_q == ST_FILL) && (cnt_q != '0);

    nios_system_dct_timeout_ctr #(
        .LIMIT (TMO_LIMIT)
    ) u_tmo (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmo_clear),
        .run     (tmo_run),
        .expired (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;

    // Partial frames leave only through test_ending in this build.
    if (FLUSH_TIMEOUT < 0) begin : g_tmo_ignored
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_FILL;
            buf_q      <= '0;
            cnt_q      <= '0;
            end_pend_q <= 1'b0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (accept) begin
                        buf_q <= buf_ins;
                        cnt_q <= cnt_inc;
                    end
                    // A same-cycle atom is packed before the end flush is judged.
                    if (test_ending) begin
                        if (cnt_after != '0) begin
                            end_pend_q <= 1'b1;
                            state_q    <= ST_EMIT;
                        end else begin
                            state_q    <= ST_DONE;
                        end
                    end else if (accept && (cnt_inc == DCT_CNT_W'(DCT_SLOTS))) begin
                        state_q <= ST_EMIT;
                    end else if (tmo_expired) begin
                        state_q <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (test_ending) begin
                        end_pend_q <= 1'b1;
                    end
                    if (dct_ready) begin
                        buf_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= (end_pend_q || test_ending) ? ST_DONE : ST_FILL;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q <= ST_FILL;
                end
            endcase
        end
    end

    assign atom_ready     = (state_q == ST_FILL);
    assign dct_valid      = (state_q == ST_EMIT);
    assign test_has_ended = (state_q == ST_DONE);
    assign dct_buffer     = buf_q;
    assign dct_count      = cnt_q;

endmodule
